// File: rtl/bias_act_unit_if.sv
// Handshake and vector bus between the dot-product stage and the bias/activation unit.
interface bias_act_unit_if #(
  parameter int unsigned NROW = 16,
  parameter int unsigned QN   = 6,
  parameter int unsigned QM   = 11
);
  localparam int unsigned BW = QN + QM + 1;
  localparam int unsigned VW = NROW * BW;

  logic          dataReady;
  logic [VW-1:0] inVector;
  logic [VW-1:0] biasVector;
  logic          actSel;
  logic [VW-1:0] outVector;
  logic          outValid;
  logic          busy;
  logic          overrun;

  modport master (
    output dataReady, inVector, biasVector, actSel,
    input  outVector, outValid, busy, overrun
  );

  modport slave (
    input  dataReady, inVector, biasVector, actSel,
    output outVector, outValid, busy, overrun
  );
endinterface

// File: rtl/bias_act_unit.sv
// Adds a bias to each element of a captured vector, saturates, and applies a hard
// sigmoid or hard tanh one element per cycle; publishes the whole vector at once.
module bias_act_unit #(
  parameter int unsigned NROW = 16,
  parameter int unsigned QN   = 6,
  parameter int unsigned QM   = 11
) (
  input  logic           clk,
  input  logic           reset,
  bias_act_unit_if.slave bus
);
  localparam int unsigned BW = QN + QM + 1;
  localparam int unsigned VW = NROW * BW;
  localparam int unsigned IW = (NROW > 1) ? $clog2(NROW) : 1;

  localparam logic signed [BW-1:0] ONE     = BW'(1 << QM);
  localparam logic signed [BW-1:0] NEG_ONE = BW'(-(1 << QM));
  localparam logic signed [BW-1:0] HALF    = BW'(1 << (QM - 1));
  localparam logic signed [BW-1:0] SMAX    = {1'b0, {(BW-1){1'b1}}};
  localparam logic signed [BW-1:0] SMIN    = {1'b1, {(BW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

  state_t                 state, next_state;
  logic [IW-1:0]          idx;
  logic [VW-1:0]          in_q, bias_q, work;
  logic                   act_q;
  logic                   capture, step, load_out, busy_d, last;
  logic signed [BW-1:0]   elem;

  // One element: widened bias add, saturate, then the selected activation.
  function automatic logic signed [BW-1:0] act_elem(input logic signed [BW-1:0] x,
                                                    input logic signed [BW-1:0] b,
                                                    input logic             tanh_sel);
    logic signed [BW:0]   s;
    logic signed [BW-1:0] sat;
    logic signed [BW-1:0] y;
    s = {x[BW-1], x} + {b[BW-1], b};
    if (s[BW] != s[BW-1]) sat = s[BW] ? SMIN : SMAX;
    else                  sat = s[BW-1:0];
    if (tanh_sel) begin
      y = sat;
      if (sat > ONE)          y = ONE;
      else if (sat < NEG_ONE) y = NEG_ONE;
    end else begin
      y = (sat >>> 2) + HALF;
      if (y[BW-1])     y = '0;
      else if (y > ONE) y = ONE;
    end
    return y;
  endfunction

  assign last = (idx == IW'(NROW - 1));

  always_comb begin
    elem = act_elem(in_q[idx*BW +: BW], bias_q[idx*BW +: BW], act_q);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.dataReady) next_state = PROC;
      PROC:    if (last)          next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    capture  = 1'b0;
    step     = 1'b0;
    load_out = 1'b0;
    busy_d   = 1'b0;
    case (state)
      IDLE: begin
        capture = bus.dataReady;
        busy_d  = bus.dataReady;
      end
      PROC: begin
        step   = 1'b1;
        busy_d = 1'b1;
      end
      DONE:    load_out = 1'b1;
      default: ;
    endcase
  end

  // Datapath and registered outputs; overrun is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx           <= '0;
      in_q          <= '0;
      bias_q        <= '0;
      act_q         <= 1'b0;
      work          <= '0;
      bus.outVector <= '0;
      bus.outValid  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.outValid <= load_out;
      bus.busy     <= busy_d;
      if (bus.dataReady && (state != IDLE)) bus.overrun <= 1'b1;
      if (capture) begin
        in_q   <= bus.inVector;
        bias_q <= bus.biasVector;
        act_q  <= bus.actSel;
        idx    <= '0;
      end
      if (step) begin
        work[idx*BW +: BW] <= elem;
        idx                <= idx + IW'(1);
      end
      if (load_out) bus.outVector <= work;
    end
  end
endmodule

// File: tb/tb_bias_act_unit.sv
// Directed and randomized checks of bias_act_unit against an arithmetic reference model.
module tb_bias_act_unit;
  localparam int unsigned NROW = 16;
  localparam int unsigned QN   = 6;
  localparam int unsigned QM   = 11;
  localparam int unsigned BW   = QN + QM + 1;
  localparam int unsigned VW   = NROW * BW;
  localparam int ONE_I  = 1 << QM;
  localparam int SMAX_I = (1 << (BW - 1)) - 1;
  localparam int SMIN_I = -(1 << (BW - 1));

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bias_act_unit_if #(.NROW(NROW), .QN(QN), .QM(QM)) bus ();
  bias_act_unit #(.NROW(NROW), .QN(QN), .QM(QM)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int xv[NROW];
  int bv[NROW];
  bit sel;

  // Reference: integer add, clamp to the signed range, then the activation rule.
  function automatic int model(input int x, input int b, input bit s);
    int t, q;
    t = x + b;
    if (t > SMAX_I) t = SMAX_I;
    if (t < SMIN_I) t = SMIN_I;
    if (s) begin
      if (t > ONE_I)  return ONE_I;
      if (t < -ONE_I) return -ONE_I;
      return t;
    end
    q = t / 4;
    if (t < 0 && q * 4 != t) q = q - 1;
    q = q + ONE_I / 2;
    if (q < 0)     q = 0;
    if (q > ONE_I) q = ONE_I;
    return q;
  endfunction

  function automatic logic [VW-1:0] pack(input int v[NROW]);
    logic [VW-1:0] p;
    for (int k = 0; k < NROW; k++) p[k*BW +: BW] = BW'(v[k]);
    return p;
  endfunction

  function automatic logic [VW-1:0] expect_vec();
    int r[NROW];
    for (int k = 0; k < NROW; k++) r[k] = model(xv[k], bv[k], sel);
    return pack(r);
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_elem(input string tag, input int k, input int val);
    logic [BW-1:0] e;
    e = BW'(val);
    chk(tag, VW'(bus.outVector[k*BW +: BW]), VW'(e));
  endtask

  function automatic int rnd(input bit full);
    logic signed [BW-1:0] r;
    if (full) begin
      r = BW'($urandom);
      return int'(r);
    end
    return int'($urandom_range(0, 12287)) - 6144;
  endfunction

  task automatic rand_vec(input bit full);
    for (int k = 0; k < NROW; k++) begin
      xv[k] = rnd(full);
      bv[k] = full ? rnd(1'b1) : int'($urandom_range(0, 1023)) - 512;
    end
  endtask

  // Drive one dataReady pulse, then scramble the inputs to prove they were captured.
  task automatic send();
    bus.inVector   = pack(xv);
    bus.biasVector = pack(bv);
    bus.actSel     = sel;
    bus.dataReady  = 1'b1;
    @(posedge clk); #1;
    bus.dataReady  = 1'b0;
    bus.inVector   = {9{$urandom()}};
    bus.biasVector = {9{$urandom()}};
    bus.actSel     = ~sel;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus.outValid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_and_check(input string tag);
    logic [VW-1:0] exp;
    int c;
    exp = expect_vec();
    send();
    wait_valid(c);
    chk({tag, "_latency"}, VW'(c), VW'(17));
    chk({tag, "_out"}, bus.outVector, exp);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, VW'(bus.outValid), VW'(0));
  endtask

  initial begin
    logic [VW-1:0] exp_a, exp_b, all_half;
    int c, c2, pulses;

    reset          = 1'b1;
    bus.dataReady  = 1'b0;
    bus.inVector   = '0;
    bus.biasVector = '0;
    bus.actSel     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", VW'(bus.busy), VW'(0));
    chk("rst_valid", VW'(bus.outValid), VW'(0));
    chk("rst_overrun", VW'(bus.overrun), VW'(0));
    chk("rst_out", bus.outVector, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    // All-zero input through the sigmoid lands exactly on one half.
    for (int k = 0; k < NROW; k++) begin
      xv[k] = 0;
      bv[k] = 0;
      all_half[k*BW +: BW] = BW'(1024);
    end
    sel = 1'b0;
    send();
    chk("zero_busy", VW'(bus.busy), VW'(1));
    wait_valid(c);
    chk("zero_latency", VW'(c), VW'(17));
    chk("zero_out", bus.outVector, all_half);
    chk("zero_busy_after", VW'(bus.busy), VW'(0));
    @(posedge clk); #1;
    chk("zero_pulse", VW'(bus.outValid), VW'(0));

    // Hard tanh clamps and passes through the linear region.
    rand_vec(1'b0);
    for (int k = 0; k < NROW; k++) bv[k] = 0;
    xv[0] = 3000; xv[1] = -5000; xv[2] = 1000; xv[3] = -1;
    sel = 1'b1;
    run_and_check("tanh");
    chk_elem("tanh_e0", 0, 2048);
    chk_elem("tanh_e1", 1, -2048);
    chk_elem("tanh_e2", 2, 1000);
    chk_elem("tanh_e3", 3, -1);

    // Hard sigmoid clamps, floor shift and bias-add saturation.
    rand_vec(1'b1);
    xv[0] = -4096;  bv[0] = 0;
    xv[1] = -1;     bv[1] = 0;
    xv[2] = 4096;   bv[2] = 0;
    xv[3] = 131071; bv[3] = 1;
    sel = 1'b0;
    run_and_check("sig");
    chk_elem("sig_e0", 0, 0);
    chk_elem("sig_e1", 1, 1023);
    chk_elem("sig_e2", 2, 2048);
    chk_elem("sig_e3", 3, 2048);

    for (int i = 0; i < 8; i++) begin
      rand_vec(i[0]);
      sel = i[1];
      run_and_check($sformatf("rand%0d", i));
    end

    // Back-to-back: second pulse lands on the edge right after outValid appears.
    rand_vec(1'b0);
    sel   = 1'b1;
    exp_a = expect_vec();
    send();
    wait_valid(c);
    chk("b2b_lat1", VW'(c), VW'(17));
    chk("b2b_out1", bus.outVector, exp_a);
    rand_vec(1'b1);
    sel   = 1'b0;
    exp_b = expect_vec();
    send();
    wait_valid(c2);
    chk("b2b_gap", VW'(c2 + 1), VW'(18));
    chk("b2b_out2", bus.outVector, exp_b);
    chk("b2b_overrun", VW'(bus.overrun), VW'(0));
    @(posedge clk); #1;

    // A second pulse while busy is dropped and flags overrun.
    rand_vec(1'b0);
    sel   = 1'b0;
    exp_a = expect_vec();
    send();
    repeat (4) @(posedge clk);
    #1;
    rand_vec(1'b1);
    bus.inVector   = pack(xv);
    bus.biasVector = pack(bv);
    bus.actSel     = 1'b1;
    bus.dataReady  = 1'b1;
    @(posedge clk); #1;
    bus.dataReady  = 1'b0;
    chk("ovr_flag", VW'(bus.overrun), VW'(1));
    wait_valid(c);
    chk("ovr_latency", VW'(c), VW'(12));
    chk("ovr_out", bus.outVector, exp_a);
    pulses = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.outValid === 1'b1) pulses++;
    end
    chk("ovr_extra_pulses", VW'(pulses), VW'(0));
    chk("ovr_sticky", VW'(bus.overrun), VW'(1));

    // Reset mid-computation wins over a coincident dataReady.
    rand_vec(1'b1);
    sel = 1'b1;
    send();
    repeat (7) @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.dataReady = 1'b1;
    @(posedge clk); #1;
    reset         = 1'b0;
    bus.dataReady = 1'b0;
    chk("mrst_busy", VW'(bus.busy), VW'(0));
    chk("mrst_valid", VW'(bus.outValid), VW'(0));
    chk("mrst_overrun", VW'(bus.overrun), VW'(0));
    chk("mrst_out", bus.outVector, '0);
    pulses = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.outValid === 1'b1) pulses++;
    end
    chk("mrst_no_pulse", VW'(pulses), VW'(0));
    rand_vec(1'b0);
    sel = 1'b0;
    run_and_check("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
